// File: rtl/canv_draw_agu_pkg.sv
// Shared defaults for the canvas drawing AGU and its combine buffer.
package canv_draw_agu_pkg;

    localparam int DEF_CORDW  = 16;  // signed pixel coordinate width
    localparam int DEF_WORD   = 32;  // VRAM word / data width
    localparam int DEF_ADDRW  = 20;  // VRAM word address width
    localparam int DEF_SHIFTW = 3;   // width of log2(pixels per word)

endpackage

// File: rtl/canv_draw_agu_wcomb.sv
// Combine buffer plus output register: merges consecutive same-word writes
// and holds one word for the VRAM port until it is accepted.
module canv_wcomb
    import canv_draw_agu_pkg::*;
#(
    parameter int ADDRW = DEF_ADDRW,
    parameter int WORD  = DEF_WORD
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADDRW-1:0] in_addr,
    input  logic [WORD-1:0]  in_data,
    input  logic [WORD-1:0]  in_mask,
    input  logic             flush_req,
    output logic             buf_valid,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [ADDRW-1:0] wr_addr,
    output logic [WORD-1:0]  wr_data,
    output logic [WORD-1:0]  wr_mask
);

    logic [ADDRW-1:0] buf_addr;
    logic [WORD-1:0]  buf_data;
    logic [WORD-1:0]  buf_mask;

    logic buf_full;
    logic same_word;
    logic need_evict;
    logic out_free;
    logic do_evict;

    // Decide whether the pending word must leave, and whether it can.
    always_comb begin
        buf_full   = buf_valid && (&buf_mask);
        same_word  = buf_valid && in_valid && (in_addr == buf_addr);
        need_evict = buf_valid && (buf_full || (in_valid && !same_word) || flush_req);
        out_free   = !wr_valid || wr_ready;
        do_evict   = need_evict && out_free;
        // An eviction that cannot happen freezes everything upstream.
        in_ready   = !(need_evict && !out_free);
    end

    // Output register: loaded on eviction, released on VRAM handshake.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_mask  <= '0;
        end else if (do_evict) begin
            wr_valid <= 1'b1;
            wr_addr  <= buf_addr;
            wr_data  <= buf_data;
            wr_mask  <= buf_mask;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

    // Combine buffer: merge same-word pixels (later wins), else reload.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_mask  <= '0;
        end else if (in_ready) begin
            if (in_valid) begin
                if (same_word && !buf_full) begin
                    buf_data <= (buf_data & ~in_mask) | in_data;
                    buf_mask <= buf_mask | in_mask;
                end else begin
                    buf_valid <= 1'b1;
                    buf_addr  <= in_addr;
                    buf_data  <= in_data;
                    buf_mask  <= in_mask;
                end
            end else if (do_evict) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/canv_draw_agu.sv
// Canvas drawing AGU: clips signed pixel writes, converts them to VRAM word
// address + data + bit mask, and merges same-word pixels before the VRAM port.
module canv_draw_agu
    import canv_draw_agu_pkg::*;
#(
    parameter int CORDW  = DEF_CORDW,
    parameter int WORD   = DEF_WORD,
    parameter int ADDRW  = DEF_ADDRW,
    parameter int PIDXW  = $clog2(WORD),
    parameter int SHIFTW = DEF_SHIFTW
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic [ADDRW-1:0]  addr_base,
    input  logic [SHIFTW-1:0] addr_shift,
    input  logic [CORDW-1:0]  canv_w,
    input  logic [CORDW-1:0]  canv_h,
    input  logic              px_valid,
    output logic              px_ready,
    input  logic [CORDW-1:0]  px_x,
    input  logic [CORDW-1:0]  px_y,
    input  logic [WORD-1:0]   px_colr,
    input  logic              flush,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDRW-1:0]  wr_addr,
    output logic [WORD-1:0]   wr_data,
    output logic [WORD-1:0]   wr_mask,
    output logic              busy
);

    localparam int LINW = ADDRW + PIDXW;
    localparam int LOGW = $clog2(WORD);

    logic                   adv;
    logic                   buf_valid;
    logic                   flush_pend;
    logic                   flush_drain;

    logic                   px_clip;
    logic [2*CORDW-1:0]     prod_c;
    logic [LINW-1:0]        lin_c;

    logic                   s1_valid;
    logic [LINW-1:0]        s1_lin;
    logic [WORD-1:0]        s1_colr;

    logic [PIDXW:0]         bpp_c;
    logic [PIDXW-1:0]       bpp_lg_c;
    logic [LINW-1:0]        sel_c;
    logic [PIDXW-1:0]       pidx_c;
    logic [PIDXW-1:0]       pos_c;
    logic [WORD-1:0]        pmask_c;

    logic                   s2_valid;
    logic [ADDRW-1:0]       s2_addr;
    logic [WORD-1:0]        s2_data;
    logic [WORD-1:0]        s2_mask;

    // Clip test and linear pixel index; negative coordinates caught by sign bit.
    always_comb begin
        px_clip = px_x[CORDW-1] || px_y[CORDW-1] || (px_x >= canv_w) || (px_y >= canv_h);
        prod_c  = (2*CORDW)'(px_y) * (2*CORDW)'(canv_w);
        lin_c   = LINW'(prod_c + (2*CORDW)'(px_x));
    end

    // Handshake and status: no new pixels while flushing, resetting or stalled.
    always_comb begin
        px_ready    = !rst_sys && !flush_pend && adv;
        flush_drain = flush_pend && !s1_valid && !s2_valid;
        busy        = s1_valid || s2_valid || buf_valid || wr_valid || flush_pend;
    end

    // Stage 1: register surviving pixels; clipped ones become bubbles.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            s1_valid <= 1'b0;
            s1_lin   <= '0;
            s1_colr  <= '0;
        end else if (adv) begin
            s1_valid <= px_valid && px_ready && !px_clip;
            s1_lin   <= lin_c;
            s1_colr  <= px_colr;
        end
    end

    // Pixel slot within the word: bpp = WORD >> shift, so bit offset = pidx << log2(bpp).
    always_comb begin
        bpp_c    = (PIDXW+1)'(WORD >> addr_shift);
        bpp_lg_c = PIDXW'(LOGW) - PIDXW'(addr_shift);
        sel_c    = (LINW'(1) << addr_shift) - LINW'(1);
        pidx_c   = PIDXW'(s1_lin & sel_c);
        pos_c    = pidx_c << bpp_lg_c;
        // Shifting by a full WORD yields zero, so bpp == WORD gives an all-ones mask.
        pmask_c  = ~({WORD{1'b1}} << bpp_c);
    end

    // Stage 2: word address, positioned colour and bit mask.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            s2_mask  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_addr  <= addr_base + ADDRW'(s1_lin >> addr_shift);
            s2_data  <= (s1_colr & pmask_c) << pos_c;
            s2_mask  <= pmask_c << pos_c;
        end
    end

    // Flush tracking: a new pulse wins over clearing; clears once nothing is buffered.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end else if (flush_pend && !s1_valid && !s2_valid && !buf_valid) begin
            flush_pend <= 1'b0;
        end
    end

    canv_wcomb #(
        .ADDRW (ADDRW),
        .WORD  (WORD)
    ) u_wcomb (
        .clk_sys   (clk_sys),
        .rst_sys   (rst_sys),
        .in_valid  (s2_valid),
        .in_ready  (adv),
        .in_addr   (s2_addr),
        .in_data   (s2_data),
        .in_mask   (s2_mask),
        .flush_req (flush_drain),
        .buf_valid (buf_valid),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask)
    );

endmodule

// File: tb/tb_canv_draw_agu.sv
// Bench for canv_draw_agu: directed cases with literal expectations plus a
// randomized phase checked against a word-grouping model of the pixel stream.
module tb_canv_draw_agu;

    localparam int CORDW  = 16;
    localparam int WORD   = 32;
    localparam int ADDRW  = 20;
    localparam int SHIFTW = 3;

    logic              clk_sys = 1'b0;
    logic              rst_sys;
    logic [ADDRW-1:0]  addr_base;
    logic [SHIFTW-1:0] addr_shift;
    logic [CORDW-1:0]  canv_w;
    logic [CORDW-1:0]  canv_h;
    logic              px_valid;
    logic              px_ready;
    logic [CORDW-1:0]  px_x;
    logic [CORDW-1:0]  px_y;
    logic [WORD-1:0]   px_colr;
    logic              flush;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDRW-1:0]  wr_addr;
    logic [WORD-1:0]   wr_data;
    logic [WORD-1:0]   wr_mask;
    logic              busy;

    canv_draw_agu dut (
        .clk_sys    (clk_sys),
        .rst_sys    (rst_sys),
        .addr_base  (addr_base),
        .addr_shift (addr_shift),
        .canv_w     (canv_w),
        .canv_h     (canv_h),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_colr    (px_colr),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [ADDRW-1:0] addr;
        logic [WORD-1:0]  data;
        logic [WORD-1:0]  mask;
    } wr_t;

    wr_t exp_q[$];
    wr_t wlog[$];
    wr_t grp;
    bit  grp_valid = 0;
    bit  bp_rand = 0;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // What a single pixel contributes to VRAM, straight from the addressing rules.
    function automatic bit pix_word(input int x, input int y, input logic [WORD-1:0] colr, output wr_t w);
        longint lin, pm, d, m;
        int bpp, pidx, cw, ch;
        cw = int'(canv_w);
        ch = int'(canv_h);
        w.addr = '0;
        w.data = '0;
        w.mask = '0;
        if (x < 0 || y < 0 || x >= cw || y >= ch) return 0;
        bpp  = WORD >> addr_shift;
        lin  = (longint'(y) * cw + x) % (longint'(1) << (ADDRW + 5));
        pidx = int'(lin % (longint'(1) << addr_shift));
        pm   = (longint'(1) << bpp) - 1;
        d    = (longint'(colr) & pm) << (pidx * bpp);
        m    = pm << (pidx * bpp);
        w.addr = ADDRW'(longint'(addr_base) + (lin >> addr_shift));
        w.data = WORD'(d);
        w.mask = WORD'(m);
        return 1;
    endfunction

    // Group accepted pixels into words: a new word closes on address change,
    // full coverage, or flush.
    function automatic void model_pixel(input int x, input int y, input logic [WORD-1:0] colr);
        wr_t w;
        if (!pix_word(x, y, colr, w)) return;
        if (grp_valid && grp.addr != w.addr) begin
            exp_q.push_back(grp);
            grp_valid = 0;
        end
        if (grp_valid) begin
            grp.data = (grp.data & ~w.mask) | w.data;
            grp.mask = grp.mask | w.mask;
        end else begin
            grp = w;
            grp_valid = 1;
        end
        if (&grp.mask) begin
            exp_q.push_back(grp);
            grp_valid = 0;
        end
    endfunction

    function automatic void model_flush();
        if (grp_valid) exp_q.push_back(grp);
        grp_valid = 0;
    endfunction

    // Compare process: tracks accepts/flushes and checks every VRAM write in order.
    always @(negedge clk_sys) begin
        wr_t e;
        if (rst_sys) begin
            exp_q.delete();
            grp_valid = 0;
        end else begin
            if (!busy) chk("idle_model_empty", 64'(exp_q.size()) + 64'(grp_valid), 64'd0);
            if (px_valid && px_ready) model_pixel(int'($signed(px_x)), int'($signed(px_y)), px_colr);
            if (flush) model_flush();
            if (wr_valid && wr_ready) begin
                wlog.push_back('{wr_addr, wr_data, wr_mask});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: actual addr 0x%0h data 0x%0h required no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                    chk("wr_mask", 64'(wr_mask), 64'(e.mask));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (bp_rand) wr_ready = ($urandom_range(0, 99) < 65);
    endtask

    task automatic px_send(input int x, input int y, input logic [WORD-1:0] c, input bit fl, output int acc);
        int n;
        bit done;
        n = 0;
        done = 0;
        px_valid = 1'b1;
        px_x = CORDW'(x);
        px_y = CORDW'(y);
        px_colr = c;
        flush = fl;
        while (!done) begin
            @(negedge clk_sys);
            if (px_ready) done = 1;
            tick();
            flush = 1'b0;
            if (!done) begin
                n++;
                if (n > 2000) begin
                    fail_now("px_accept_timeout");
                    done = 1;
                end
            end
        end
        acc = cyc;
        px_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (busy && n < 3000) begin
            tick();
            @(negedge clk_sys);
            n++;
        end
        if (busy) fail_now(name);
        tick();
    endtask

    task automatic chk_wr(input int idx, input logic [ADDRW-1:0] a, input logic [WORD-1:0] d, input logic [WORD-1:0] m);
        if (idx >= wlog.size()) begin
            fail_now("missing_write");
        end else begin
            chk("log_addr", 64'(wlog[idx].addr), 64'(a));
            chk("log_data", 64'(wlog[idx].data), 64'(d));
            chk("log_mask", 64'(wlog[idx].mask), 64'(m));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int acc, last, n, x, y, lastx;
        bit ok;
        wr_t w;

        rst_sys = 1'b1;
        flush = 1'b0;
        px_valid = 1'b0;
        px_x = '0;
        px_y = '0;
        px_colr = '0;
        wr_ready = 1'b1;
        addr_base = 20'h01000;
        addr_shift = 3'd2;
        canv_w = 16'd320;
        canv_h = 16'd240;

        // Pin the reference model against hand-computed words.
        ok = pix_word(5, 2, 32'hAB, w);
        chk("model_pix_addr", 64'(w.addr), 64'h10A1);
        chk("model_pix_data", 64'(w.data), 64'h0000AB00);
        chk("model_pix_mask", 64'(w.mask), 64'h0000FF00);
        ok = pix_word(320, 0, 32'h11, w);
        chk("model_clip", 64'(ok), 64'd0);

        repeat (3) tick();
        @(negedge clk_sys);
        chk("rst_px_ready", 64'(px_ready), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wr_mask", 64'(wr_mask), 64'd0);
        tick();
        rst_sys = 1'b0;
        @(negedge clk_sys);
        chk("post_rst_px_ready", 64'(px_ready), 64'd1);
        tick();

        // Single pixel then flush.
        wlog.delete();
        px_send(5, 2, 32'hAB, 0, acc);
        pulse_flush();
        wait_idle("single_idle");
        chk("single_count", 64'(wlog.size()), 64'd1);
        chk_wr(0, 20'h010A1, 32'h0000AB00, 32'h0000FF00);

        // Flush with nothing pending clears after one cycle.
        pulse_flush();
        @(negedge clk_sys);
        chk("empty_flush_busy1", 64'(busy), 64'd1);
        tick();
        @(negedge clk_sys);
        chk("empty_flush_busy2", 64'(busy), 64'd0);
        tick();

        // Full word, back-to-back, no flush.
        wlog.delete();
        px_send(0, 0, 32'h11, 0, acc);
        px_send(1, 0, 32'h22, 0, acc);
        px_send(2, 0, 32'h33, 0, acc);
        px_send(3, 0, 32'h44, 0, last);
        n = 0;
        @(negedge clk_sys);
        while (!wr_valid && n < 20) begin
            tick();
            @(negedge clk_sys);
            n++;
        end
        chk("full_latency", 64'(cyc - last), 64'd3);
        tick();
        wait_idle("full_idle");
        chk("full_count", 64'(wlog.size()), 64'd1);
        chk_wr(0, 20'h01000, 32'h44332211, 32'hFFFFFFFF);

        // Clipped pixels are swallowed.
        wlog.delete();
        px_send(-1, 0, 32'h5A, 0, acc);
        px_send(320, 0, 32'h5B, 0, acc);
        px_send(0, 240, 32'h5C, 0, acc);
        tick();
        tick();
        @(negedge clk_sys);
        chk("clip_busy", 64'(busy), 64'd0);
        repeat (6) tick();
        chk("clip_count", 64'(wlog.size()), 64'd0);

        // Back-pressure: output stuck, pipeline must freeze without loss.
        wlog.delete();
        wr_ready = 1'b0;
        px_send(0, 0, 32'hC0, 0, acc);
        px_send(4, 0, 32'hC1, 0, acc);
        px_send(8, 0, 32'hC2, 0, acc);
        px_send(12, 0, 32'hC3, 0, acc);
        repeat (4) tick();
        @(negedge clk_sys);
        chk("bp_px_ready", 64'(px_ready), 64'd0);
        chk("bp_wr_valid", 64'(wr_valid), 64'd1);
        chk("bp_wr_addr", 64'(wr_addr), 64'h1000);
        tick();
        wr_ready = 1'b1;
        pulse_flush();
        wait_idle("bp_idle");
        chk("bp_count", 64'(wlog.size()), 64'd4);
        chk_wr(0, 20'h01000, 32'h000000C0, 32'h000000FF);
        chk_wr(1, 20'h01001, 32'h000000C1, 32'h000000FF);
        chk_wr(2, 20'h01002, 32'h000000C2, 32'h000000FF);
        chk_wr(3, 20'h01003, 32'h000000C3, 32'h000000FF);

        // Overwrite of the same pixel: later colour wins.
        wlog.delete();
        px_send(1, 0, 32'h01, 0, acc);
        px_send(1, 0, 32'h02, 0, acc);
        pulse_flush();
        wait_idle("ovw_idle");
        chk("ovw_count", 64'(wlog.size()), 64'd1);
        chk_wr(0, 20'h01000, 32'h00000200, 32'h0000FF00);

        // Pixel accepted in the flush cycle is part of that flush.
        wlog.delete();
        px_send(6, 0, 32'h77, 1, acc);
        wait_idle("flush_same_idle");
        chk("flush_same_count", 64'(wlog.size()), 64'd1);
        chk_wr(0, 20'h01001, 32'h00770000, 32'h00FF0000);

        // Reset with a pixel sitting in the buffer.
        wlog.delete();
        px_send(0, 0, 32'h55, 0, acc);
        repeat (3) tick();
        rst_sys = 1'b1;
        tick();
        rst_sys = 1'b0;
        @(negedge clk_sys);
        chk("midrst_wr_valid", 64'(wr_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (10) tick();
        chk("midrst_count", 64'(wlog.size()), 64'd0);

        // Randomized traffic against the grouping model.
        bp_rand = 1;
        for (int r = 0; r < 8; r++) begin
            addr_shift = SHIFTW'($urandom_range(0, 5));
            canv_w = CORDW'($urandom_range(4, 40));
            canv_h = CORDW'($urandom_range(2, 20));
            addr_base = ADDRW'($urandom);
            lastx = 0;
            y = 0;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                if ($urandom_range(0, 1) == 0) begin
                    x = lastx + 1;
                end else begin
                    x = int'($urandom_range(0, int'(canv_w) + 5)) - 3;
                    y = int'($urandom_range(0, int'(canv_h) + 3)) - 2;
                end
                lastx = x;
                px_send(x, y, $urandom, ($urandom_range(0, 29) == 0), acc);
            end
            pulse_flush();
            wait_idle("rand_idle");
            chk("rand_model_drained", 64'(exp_q.size()) + 64'(grp_valid), 64'd0);
        end
        bp_rand = 0;
        wr_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
